sum_bcd_display: RTL and testbench

- Downstream consumer of the sumitup stage. On each `done` from the adder it latches `sum` into a result register that drives the testbench's compare input.
- It converts the captured value to decimal with a sequential shift-add-3 (double-dabble) engine.
- It drives four active-low 7-segment digits with leading-zero blanking and an overflow indication.

---
 rtl/sum_bcd_display_if.sv | 11 +
 rtl/sum_bcd_display.sv | 124 ++++++++++++
 tb/tb_sum_bcd_display.sv | 108 ++++++++++
 3 files changed

// File: rtl/sum_bcd_display_if.sv
// sum_bcd_display_if: adder result handoff and 7-segment display bus (done/sum in; result, hex3..hex0, busy, valid out)
interface sum_bcd_display_if #(parameter int SUM_W = 16);
  logic             done;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] result;
  logic [6:0]       hex3, hex2, hex1, hex0;
  logic             busy;
  logic             valid;
  modport master (output done, sum, input result, hex3, hex2, hex1, hex0, busy, valid);
  modport slave  (input done, sum, output result, hex3, hex2, hex1, hex0, busy, valid);
endinterface

// File: rtl/sum_bcd_display.sv
// sum_bcd_display: captures sum on rising done, converts to decimal (double-dabble) and drives 4 active-low 7-seg digits; ports ck, reset_l (async active-low), bus (slave: done, sum -> result, hex3..hex0, busy, valid); define SUM_HEX_MODE_EN for raw hex digits without the BCD engine
module sum_bcd_display #(
  parameter int SUM_W  = 16,
  parameter int DIGITS = 4
) (
  input logic               ck,
  input logic               reset_l,
  sum_bcd_display_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
  localparam logic [6:0] SEG_LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  state_t     state, nxt;
  logic       done_q, pending, cap, pend, last;
  logic [6:0] nh3, nh2, nh1, nh0;
  assign cap  = bus.done & ~done_q;
  // a capture landing on the UPDATE edge itself counts as pending too
  assign pend = pending | cap;
`ifdef SUM_HEX_MODE_EN
  logic [15:0] r16;
  assign last = 1'b1;
  assign r16  = 16'(bus.result);
  always_comb begin
    nh3 = SEG_LUT[r16[15:12]];
    nh2 = SEG_LUT[r16[11:8]];
    nh1 = SEG_LUT[r16[7:4]];
    nh0 = SEG_LUT[r16[3:0]];
  end
`else
  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(SUM_W);
  logic [SUM_W-1:0] shift;
  logic [BCD_W-1:0] bcd, adj;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic [SUM_W-1:0] ld_val;
  assign last   = cnt == CW'(SUM_W - 1);
  assign ld_val = cap ? bus.sum : bus.result;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  always_comb begin
    nh3 = ovf ? 7'h3F : ~|bcd[15:12] ? 7'h7F : SEG_LUT[bcd[15:12]];
    nh2 = ovf ? 7'h3F : ~|bcd[15:8]  ? 7'h7F : SEG_LUT[bcd[11:8]];
    nh1 = ovf ? 7'h3F : ~|bcd[15:4]  ? 7'h7F : SEG_LUT[bcd[7:4]];
    nh0 = ovf ? 7'h3F : SEG_LUT[bcd[3:0]];
  end
`endif
  always_ff @(posedge ck or negedge reset_l)
    if (!reset_l) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = cap ? CONVERT : IDLE;
      CONVERT: nxt = last ? UPDATE : CONVERT;
      UPDATE:  nxt = pend ? CONVERT : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge ck or negedge reset_l)
    if (!reset_l) begin
      done_q     <= 1'b0;
      pending    <= 1'b0;
      bus.result <= '0;
      bus.busy   <= 1'b0;
      bus.valid  <= 1'b0;
      bus.hex3   <= 7'h7F;
      bus.hex2   <= 7'h7F;
      bus.hex1   <= 7'h7F;
      bus.hex0   <= 7'h40;
`ifndef SUM_HEX_MODE_EN
      shift      <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
`endif
    end else begin
      done_q <= bus.done;
      if (cap) begin
        bus.result <= bus.sum;
        bus.valid  <= 1'b0;
      end
      if (cap && state != IDLE) pending <= 1'b1;
      unique case (state)
`ifdef SUM_HEX_MODE_EN
        IDLE: ;
        CONVERT: bus.busy <= 1'b1;
`else
        IDLE: if (cap) begin
          shift    <= bus.sum;
          bcd      <= '0;
          cnt      <= '0;
          ovf      <= 1'b0;
          bus.busy <= 1'b1;
        end
        CONVERT: begin
          {bcd, shift} <= {adj[BCD_W-2:0], shift, 1'b0};
          ovf          <= ovf | adj[BCD_W-1];
          cnt          <= cnt + 1'b1;
        end
`endif
        UPDATE: if (pend) begin
          pending <= 1'b0;
`ifndef SUM_HEX_MODE_EN
          shift   <= ld_val;
          bcd     <= '0;
          cnt     <= '0;
          ovf     <= 1'b0;
`endif
        end else begin
          bus.hex3  <= nh3;
          bus.hex2  <= nh2;
          bus.hex1  <= nh1;
          bus.hex0  <= nh0;
          bus.valid <= 1'b1;
          bus.busy  <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sum_bcd_display.sv
// tb_sum_bcd_display: directed checks of capture, decimal conversion, blanking, overflow, pending restart and reset abort
module tb_sum_bcd_display;
  logic ck = 1'b0;
  logic reset_l = 1'b0;
  int checks = 0;
  int errors = 0;
  sum_bcd_display_if #(.SUM_W(16)) bus ();
  sum_bcd_display #(.SUM_W(16), .DIGITS(4)) dut (.ck(ck), .reset_l(reset_l), .bus(bus));
  always #5 ck = ~ck;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask
  task automatic start(input logic [15:0] s, input int held);
    bus.sum  = s;
    bus.done = 1'b1;
    tick(held);
    bus.done = 1'b0;
  endtask
  task automatic chk_hex(input string tag, input logic [6:0] h3, h2, h1, h0);
    chk({tag, "_hex3"}, 32'(bus.hex3), 32'(h3));
    chk({tag, "_hex2"}, 32'(bus.hex2), 32'(h2));
    chk({tag, "_hex1"}, 32'(bus.hex1), 32'(h1));
    chk({tag, "_hex0"}, 32'(bus.hex0), 32'(h0));
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_result"}, 32'(bus.result), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
    chk_hex(tag, 7'h7F, 7'h7F, 7'h7F, 7'h40);
  endtask
  // single-cycle done: capture on E0, valid must rise exactly on E17
  task automatic convert(input string tag, input logic [15:0] s, input logic [6:0] h3, h2, h1, h0);
    start(s, 1);
    chk({tag, "_result"}, 32'(bus.result), 32'(s));
    chk({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    chk({tag, "_valid_e0"}, 32'(bus.valid), 32'd0);
    tick(16);
    chk({tag, "_valid_e16"}, 32'(bus.valid), 32'd0);
    tick(1);
    chk({tag, "_valid_e17"}, 32'(bus.valid), 32'd1);
    chk({tag, "_busy_e17"}, 32'(bus.busy), 32'd0);
    chk_hex(tag, h3, h2, h1, h0);
    tick(2);
  endtask
  initial begin
    int bad;
    bus.done = 1'b0;
    bus.sum  = '0;
    tick(2);
    chk_reset("rst");
    reset_l = 1'b1;
    tick(2);
    convert("s1234", 16'd1234, 7'h79, 7'h24, 7'h30, 7'h19);
    convert("s7", 16'd7, 7'h7F, 7'h7F, 7'h7F, 7'h78);
    convert("s0", 16'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    convert("s9999", 16'd9999, 7'h10, 7'h10, 7'h10, 7'h10);
    convert("s10000", 16'd10000, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    convert("s305", 16'd305, 7'h7F, 7'h30, 7'h40, 7'h12);
    start(16'd55, 5);
    chk("hold_result", 32'(bus.result), 32'd55);
    tick(12);
    chk("hold_valid_e16", 32'(bus.valid), 32'd0);
    tick(1);
    chk("hold_valid_e17", 32'(bus.valid), 32'd1);
    chk_hex("hold", 7'h7F, 7'h7F, 7'h12, 7'h12);
    tick(20);
    chk("hold_busy_after", 32'(bus.busy), 32'd0);
    chk("hold_valid_after", 32'(bus.valid), 32'd1);
    start(16'd100, 1);
    tick(5);
    start(16'd4321, 1);
    chk("pend_result", 32'(bus.result), 32'd4321);
    chk("pend_valid_e6", 32'(bus.valid), 32'd0);
    bad = 0;
    for (int i = 0; i < 27; i++) begin
      tick(1);
      if (bus.valid !== 1'b0 || bus.hex2 === 7'h79) bad++;
    end
    chk("pend_no_early_show", 32'(bad), 32'd0);
    chk("pend_busy_e33", 32'(bus.busy), 32'd1);
    tick(1);
    chk("pend_valid_e34", 32'(bus.valid), 32'd1);
    chk("pend_busy_e34", 32'(bus.busy), 32'd0);
    chk_hex("pend", 7'h19, 7'h30, 7'h24, 7'h79);
    tick(3);
    start(16'd8888, 1);
    tick(8);
    reset_l = 1'b0;
    #1;
    chk_reset("abort");
    tick(1);
    reset_l = 1'b1;
    tick(2);
    convert("s42", 16'd42, 7'h7F, 7'h7F, 7'h19, 7'h24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
